update_ctrl: RTL and testbench

Sequencer for the update path of the fractured SRL-based CAM. It accepts one rule-write or rule-invalidate request at a time and, for writes, drives the key, address counter, SRL clock-enable one-hot and write strobe for the downstream compare/SRL stage. That stage shifts one match bit per cycle into the selected SRL32 column. Between updates the block passes the lookup key through, and it keeps a per-rule valid bitmap that the match path uses to mask stale or partially written columns.

---
 rtl/fractcam_pkg.sv | 19 +
 rtl/rule_decoder.sv | 22 ++
 rtl/update_ctrl.sv | 134 +++++++++++++
 tb/tb_update_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fractcam_pkg.sv
// Shared definitions for the fractured SRL-based CAM.
// Holds the key/rule geometry, the update-FSM state encoding and the request
// op encodings used by the update sequencer and the match-path masking.
package fractcam_pkg;

    localparam int KEY_W     = 5;
    localparam int RULE_W    = 3;
    localparam int NUM_RULE  = 2 ** RULE_W;
    localparam int SRL_DEPTH = 2 ** KEY_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_INV   = 1'b1;

endpackage

// File: rtl/rule_decoder.sv
// One-hot decoder from a rule id to a per-column select vector.
// Ports:
//   i_en      - when low the output is all zeros
//   i_sel     - rule id (RULE_W bits)
//   o_onehot  - NUM_RULE-bit one-hot of i_sel, gated by i_en
module rule_decoder #(
    parameter int RULE_W   = fractcam_pkg::RULE_W,
    parameter int NUM_RULE = fractcam_pkg::NUM_RULE
) (
    input  logic                i_en,
    input  logic [RULE_W-1:0]   i_sel,
    output logic [NUM_RULE-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/update_ctrl.sv
// Update-path sequencer for the fractured SRL-based CAM.
// Accepts one write/invalidate request at a time. A write shifts 2**KEY_W
// match bits into the selected SRL column (count runs from top address down
// to 0), then marks the column valid. An invalidate clears the column's valid
// bit immediately. Between updates the lookup key is passed to the compare
// stage.
// Ports:
//   wclk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready       - request handshake (ready only when idle)
//   req_op/req_key/req_rule   - request op (0 write, 1 invalidate), key, column
//   lkp_key                   - search key, forwarded to sk while idle
//   sk                        - key to the compare stage
//   count                     - SRL address / shift index
//   srl_ce                    - one-hot SRL column enable
//   wr, busy                  - shifting in progress
//   done                      - one-cycle completion pulse
//   rule_valid                - per-column valid bitmap
module update_ctrl #(
    parameter int KEY_W    = fractcam_pkg::KEY_W,
    parameter int RULE_W   = fractcam_pkg::RULE_W,
    parameter int NUM_RULE = fractcam_pkg::NUM_RULE
) (
    input  logic                wclk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_op,
    input  logic [KEY_W-1:0]    req_key,
    input  logic [RULE_W-1:0]   req_rule,
    input  logic [KEY_W-1:0]    lkp_key,
    output logic [KEY_W-1:0]    sk,
    output logic [KEY_W-1:0]    count,
    output logic [NUM_RULE-1:0] srl_ce,
    output logic                wr,
    output logic                busy,
    output logic                done,
    output logic [NUM_RULE-1:0] rule_valid
);

    localparam logic [KEY_W-1:0] CNT_MAX = KEY_W'(2 ** KEY_W - 1);

    fractcam_pkg::state_t r_state;
    logic [KEY_W-1:0]     r_count;
    logic [KEY_W-1:0]     r_sk;
    logic [NUM_RULE-1:0]  r_srl_ce;
    logic                 r_wr;
    logic                 r_busy;
    logic                 r_done;
    logic [NUM_RULE-1:0]  r_rule_valid;

    logic                 w_idle;
    logic                 w_accept;
    logic                 w_wr_acc;
    logic                 w_inv_acc;
    logic [NUM_RULE-1:0]  w_req_onehot;

    assign w_idle    = (r_state == fractcam_pkg::IDLE);
    assign w_accept  = req_valid && w_idle;
    assign w_wr_acc  = w_accept && (req_op == fractcam_pkg::OP_WRITE);
    assign w_inv_acc = w_accept && (req_op == fractcam_pkg::OP_INV);

    rule_decoder #(
        .RULE_W   (RULE_W),
        .NUM_RULE (NUM_RULE)
    ) u_rule_decoder (
        .i_en     (w_accept),
        .i_sel    (req_rule),
        .o_onehot (w_req_onehot)
    );

    always_ff @(posedge wclk) begin
        if (rst) begin
            r_state      <= fractcam_pkg::IDLE;
            r_count      <= '0;
            r_srl_ce     <= '0;
            r_wr         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rule_valid <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                fractcam_pkg::IDLE: begin
                    if (w_wr_acc) begin
                        // Valid drops for the whole shift so a partially
                        // rewritten column is never reported as a match.
                        r_state      <= fractcam_pkg::SHIFT;
                        r_count      <= CNT_MAX;
                        r_srl_ce     <= w_req_onehot;
                        r_wr         <= 1'b1;
                        r_busy       <= 1'b1;
                        r_rule_valid <= r_rule_valid & ~w_req_onehot;
                    end else if (w_inv_acc) begin
                        r_rule_valid <= r_rule_valid & ~w_req_onehot;
                        r_done       <= 1'b1;
                    end
                end
                fractcam_pkg::SHIFT: begin
                    if (r_count == '0) begin
                        // srl_ce still holds the one-hot of the target column.
                        r_state      <= fractcam_pkg::IDLE;
                        r_srl_ce     <= '0;
                        r_wr         <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_rule_valid <= r_rule_valid | r_srl_ce;
                    end else begin
                        r_count <= r_count - KEY_W'(1);
                    end
                end
                default: begin
                    r_state <= fractcam_pkg::IDLE;
                end
            endcase
        end
    end

    // Write key capture; data only, so it carries no reset.
    always_ff @(posedge wclk) begin
        if (w_wr_acc) begin
            r_sk <= req_key;
        end
    end

    assign req_ready  = w_idle;
    assign sk         = w_idle ? lkp_key : r_sk;
    assign count      = r_count;
    assign srl_ce     = r_srl_ce;
    assign wr         = r_wr;
    assign busy       = r_busy;
    assign done       = r_done;
    assign rule_valid = r_rule_valid;

endmodule

// File: tb/tb_update_ctrl.sv
module tb_update_ctrl;

    logic       wclk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [4:0] req_key;
    logic [2:0] req_rule;
    logic [4:0] lkp_key;
    logic [4:0] sk;
    logic [4:0] count;
    logic [7:0] srl_ce;
    logic       wr;
    logic       busy;
    logic       done;
    logic [7:0] rule_valid;

    int checks = 0;
    int errors = 0;

    // Reference: valid bitmap as the specification defines it.
    logic [7:0] model_valid;

    update_ctrl dut (
        .wclk       (wclk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_key    (req_key),
        .req_rule   (req_rule),
        .lkp_key    (lkp_key),
        .sk         (sk),
        .count      (count),
        .srl_ce     (srl_ce),
        .wr         (wr),
        .busy       (busy),
        .done       (done),
        .rule_valid (rule_valid)
    );

    always #5 wclk = ~wclk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_wr"}, 32'(wr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_srl_ce"}, 32'(srl_ce), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_valid"}, 32'(rule_valid), 32'(model_valid));
    endtask

    // Caller has already driven the write request. Returns in the done cycle,
    // with the "during shift" inputs (n*) still driven.
    task automatic do_write(input logic [4:0] key, input logic [2:0] rule,
                            input logic nv, input logic nop,
                            input logic [4:0] nkey, input logic [2:0] nrule);
        logic [31:0] col;
        step();
        model_valid[rule] = 1'b0;
        req_valid = nv;
        req_op    = nop;
        req_key   = nkey;
        req_rule  = nrule;
        col = '0;
        for (int i = 0; i < 32; i++) begin
            lkp_key = 5'($urandom);
            #1;
            chk("sh_wr", 32'(wr), 32'd1);
            chk("sh_busy", 32'(busy), 32'd1);
            chk("sh_ready", 32'(req_ready), 32'd0);
            chk("sh_done", 32'(done), 32'd0);
            chk("sh_count", 32'(count), 32'(31 - i));
            chk("sh_srl_ce", 32'(srl_ce), 32'd1 << rule);
            chk("sh_sk", 32'(sk), 32'(key));
            chk("sh_valid", 32'(rule_valid), 32'(model_valid));
            // Downstream SRL column: newest bit enters address 0.
            if (wr && srl_ce[rule]) col = {col[30:0], (count == sk)};
            step();
        end
        model_valid[rule] = 1'b1;
        chk("wdone_done", 32'(done), 32'd1);
        chk_idle("wdone");
        chk("srl_column", col, 32'd1 << key);
    endtask

    task automatic do_inv(input logic [2:0] rule);
        req_valid = 1'b1;
        req_op    = 1'b1;
        req_rule  = rule;
        req_key   = 5'($urandom);
        step();
        model_valid[rule] = 1'b0;
        chk("inv_done", 32'(done), 32'd1);
        chk_idle("inv");
        req_valid = 1'b0;
        step();
        chk("inv_done_clr", 32'(done), 32'd0);
        chk_idle("inv_after");
    endtask

    task automatic drive_write(input logic [4:0] key, input logic [2:0] rule);
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_key   = key;
        req_rule  = rule;
    endtask

    initial begin
        logic [4:0] k;
        logic [2:0] r;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_op      = 1'b0;
        req_key     = '0;
        req_rule    = '0;
        lkp_key     = '0;
        model_valid = '0;

        step();
        step();
        chk("rst_done", 32'(done), 32'd0);
        chk_idle("rst");
        rst = 1'b0;
        step();

        // Idle passthrough is combinational.
        lkp_key = 5'd17;
        #1;
        chk("idle_sk17", 32'(sk), 32'd17);

        // Single write, key 5 into rule 2.
        drive_write(5'd5, 3'd2);
        do_write(5'd5, 3'd2, 1'b0, 1'b0, 5'd0, 3'd0);
        chk("w5_valid_lit", 32'(rule_valid), 32'h04);
        step();
        chk("w5_done_once", 32'(done), 32'd0);
        do_inv(3'd2);

        // Back-to-back writes with req_valid held; boundary keys 0 and 31.
        drive_write(5'd0, 3'd0);
        do_write(5'd0, 3'd0, 1'b1, 1'b0, 5'd31, 3'd7);
        do_write(5'd31, 3'd7, 1'b0, 1'b0, 5'd0, 3'd0);
        chk("b2b_valid_lit", 32'(rule_valid), 32'h81);
        step();

        // Invalidate rule 7.
        do_inv(3'd7);
        chk("inv7_valid_lit", 32'(rule_valid), 32'h01);

        // Back-to-back invalidates, one per cycle.
        drive_write(5'd9, 3'd3);
        do_write(5'd9, 3'd3, 1'b0, 1'b0, 5'd0, 3'd0);
        step();
        req_valid = 1'b1; req_op = 1'b1; req_rule = 3'd3;
        step();
        model_valid[3] = 1'b0;
        chk("inv_b2b1_done", 32'(done), 32'd1);
        chk("inv_b2b1_valid", 32'(rule_valid), 32'(model_valid));
        req_rule = 3'd0;
        step();
        model_valid[0] = 1'b0;
        chk("inv_b2b2_done", 32'(done), 32'd1);
        chk("inv_b2b2_valid", 32'(rule_valid), 32'h00);
        req_valid = 1'b0;
        step();

        // Reset at the 10th shift cycle.
        drive_write(5'd12, 3'd4);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("mid_count", 32'(count), 32'd22);
        chk("mid_wr", 32'(wr), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_valid = '0;
        chk("mid_rst_done", 32'(done), 32'd0);
        chk_idle("mid_rst");

        // Subsequent write completes normally.
        drive_write(5'd12, 3'd4);
        do_write(5'd12, 3'd4, 1'b0, 1'b0, 5'd0, 3'd0);
        step();

        // Requests during SHIFT are ignored.
        drive_write(5'd20, 3'd6);
        do_write(5'd20, 3'd6, 1'b1, 1'b1, 5'd3, 3'd4);
        req_valid = 1'b0;
        chk("noise_valid", 32'(rule_valid), 32'(model_valid));
        step();

        // Randomized mix of writes, invalidates and idle lookups.
        for (int n = 0; n < 16; n++) begin
            k = 5'($urandom);
            r = 3'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                do_inv(r);
            end else begin
                drive_write(k, r);
                do_write(k, r, 1'($urandom), 1'($urandom), 5'($urandom), 3'($urandom));
                req_valid = 1'b0;
                step();
                chk("rnd_done_clr", 32'(done), 32'd0);
            end
            lkp_key = 5'($urandom);
            #1;
            chk("rnd_idle_sk", 32'(sk), 32'(lkp_key));
            chk_idle("rnd_idle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
